// File: rtl/asmd_interpolator.sv
// Linear-interpolating up-sampler: emits L = 2^LOG2_L samples per loaded word.
// ASMD: three-state controller driving an accumulator datapath.
module asmd_interpolator #(
  parameter int LOG2_L = 2,
  parameter int W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      Din,
  input  logic              Ld,
  input  logic              En,
  output logic [W-1:0]      Dout,
  output logic              Valid,
  output logic              Ready,
  output logic [LOG2_L-1:0] Phase
);

  localparam int L  = 1 << LOG2_L;
  localparam int AW = W + LOG2_L + 2;
  localparam logic [LOG2_L-1:0] K_PEN  = LOG2_L'(L - 2);
  localparam logic [LOG2_L-1:0] K_LAST = LOG2_L'(L - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_LAST
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]      prev, cur;
  logic [W:0]        diff;
  logic [AW-1:0]     acc;
  logic [AW-1:0]     acc_sum;
  logic [AW-1:0]     acc_init;
  logic [LOG2_L-1:0] k;
  logic              load, step, fin;

  assign acc_sum  = acc + {{(AW-W-1){diff[W]}}, diff};
  assign acc_init = {{(AW-W-LOG2_L){prev[W-1]}}, prev, {LOG2_L{1'b0}}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // S_LAST owns the final output of a group so the endpoint is exact.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    Ready     = (state == S_IDLE);
    case (state)
      S_IDLE: begin
        if (Ld) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (En) begin
          step = 1'b1;
          if (k == K_PEN) state_nxt = S_LAST;
        end
      end
      S_LAST: begin
        if (En) begin
          fin       = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev  <= '0;
      cur   <= '0;
      diff  <= '0;
      acc   <= '0;
      k     <= '0;
      Dout  <= '0;
      Valid <= 1'b0;
      Phase <= '0;
    end else begin
      Valid <= step | fin;
      if (load) begin
        cur  <= Din;
        diff <= {Din[W-1], Din} - {prev[W-1], prev};
        acc  <= acc_init;
        k    <= '0;
      end
      if (step) begin
        acc   <= acc_sum;
        Dout  <= acc_sum[W+LOG2_L-1:LOG2_L];
        Phase <= k;
        k     <= k + LOG2_L'(1);
      end
      if (fin) begin
        Dout  <= cur;
        Phase <= K_LAST;
        prev  <= cur;
      end
    end
  end

endmodule
